sc_melodyseq: RTL and testbench
===============================

Name: sc_melodyseq

Overview:
- Note sequencer that sits directly upstream of the frequency generator.
- Steps through a fixed 8-entry melody table and drives the generator's half-period divider value and tone-enable.
- Each note is held for a programmable number of time ticks derived from CLOCK_50.
- Provides start/stop/loop control and busy/done status for board-level control logic.

Parameters:
DIVIDER_WIDTH, 17, width of half-period divider output (50 MHz / (2·f)).
TICK_CYCLES, 2500000, CLOCK_50 cycles per duration tick (50 ms); must be >= 2.
NOTES, 8, melody table depth; step index width = 3.

Ports:
SC_MELODYSEQ_CLOCK_50  input  1  system clock, 50 MHz.
SC_MELODYSEQ_RESET_InLow  input  1  asynchronous active-low reset.
SC_MELODYSEQ_start_In  input  1  start request, sampled each clock edge.
SC_MELODYSEQ_stop_In  input  1  abort request, sampled each clock edge.
SC_MELODYSEQ_loop_In  input  1  level; when 1, the melody restarts after step 7.
SC_MELODYSEQ_divider_OutBUS  output  DIVIDER_WIDTH  half-period count to the frequency generator; 0 = silent.
SC_MELODYSEQ_toneEnable_Out  output  1  1 while a non-rest note plays.
SC_MELODYSEQ_step_OutBUS  output  3  current table index.
SC_MELODYSEQ_busy_Out  output  1  1 in LOAD or PLAY.
SC_MELODYSEQ_done_Out  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: asynchronous and active-low. Asserting it at any time forces state IDLE and clears all outputs, step, tick and duration counters.
- Note code to divider mapping (combinational ROM):
  - 0 = rest → 0
  - 1 → 95420, 2 → 85034, 3 → 75758, 4 → 71633
  - 5 → 63776, 6 → 56818, 7 → 50607, 8 → 47801
  - 9–15 → treated as rest.
- Melody table, step:(code,ticks): 0:(1,4) 1:(2,4) 2:(3,4) 3:(0,2) 4:(5,4) 5:(6,4) 6:(8,8) 7:(0,4). A tick value of 0 is treated as 1.
- FSM states: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - divider=0, toneEnable=0, busy=0, step=0.
  - start=1 and stop=0 → LOAD.
- LOAD (1 cycle):
  - On exit, register divider/toneEnable from table[step].
  - Load duration counter with ticks and clear the tick counter.
  - → PLAY.
  - During LOAD, divider/toneEnable hold their previous values (no glitch to 0 between notes).
- PLAY:
  - Tick counter counts 0..TICK_CYCLES-1 and wraps; each wrap decrements the duration counter.
  - On the wrap where duration==1:
    - step<7 → step+1, LOAD.
    - step==7 and loop=1 → step=0, LOAD.
    - step==7 and loop=0 → DONE.
  - loop_In is sampled only at that final wrap.
- DONE (1 cycle):
  - done_Out=1, divider=0, toneEnable=0, step held at 7.
  - → IDLE, with step cleared to 0.
- stop=1 in LOAD or PLAY → IDLE on the next edge, divider/toneEnable cleared, step=0, no done pulse.
- stop has priority over start.
- start while busy is ignored; no restart.
- Latency: start sampled at edge k → divider valid after edge k+1.
- Each step occupies exactly 1 + ticks·TICK_CYCLES cycles.
- Full non-looped run: 8 + 34·TICK_CYCLES cycles from the LOAD entry to DONE entry.
- Outputs are registered, except busy_Out and done_Out, which are decoded from state.

Test Plan:
1. Reset value check: TICK_CYCLES=4. Assert RESET_InLow=0 mid-PLAY → all outputs 0 immediately (asynchronously); after release, state stays IDLE with no start.
2. Single run: start pulse at edge 0.
   - divider=95420 and toneEnable=1 after edge 1.
   - divider=85034 after edge 18.
   - done_Out high exactly one cycle, entered at edge 144; busy low afterwards; step returns to 0.
3. Rest step: during step 3, divider=0 and toneEnable=0 for 9 cycles (LOAD + 8); during step 6, divider=47801 for 33 cycles.
4. Loop: loop_In=1 → after step 7, step wraps to 0 with divider=95420; no done pulse. Drop loop_In mid-run → done after the current pass.
5. Stop/start interaction:
   - stop during step 2 → IDLE next cycle, outputs 0, no done.
   - start and stop in the same cycle from IDLE → stays IDLE.
   - start while busy → divider sequence unchanged.
6. Boundary: TICK_CYCLES=2, with a table entry forced to ticks=0 in a bench variant → that step lasts 3 cycles (treated as 1 tick).

Source files
------------

// File: rtl/sc_melodyseq.sv
// Melody sequencer: walks an 8-step note table and feeds the half-period divider
// and tone-enable of the downstream frequency generator, with start/stop/loop control.
module sc_melodyseq #(
  parameter int                  DIVIDER_WIDTH = 17,
  parameter int                  TICK_CYCLES   = 2500000,
  parameter int                  NOTES         = 8,
  // Step i lives in nibble [4*i +: 4]; codes and tick counts per step.
  parameter logic [NOTES*4-1:0]  CODE_TABLE    = 32'h0865_0321,
  parameter logic [NOTES*4-1:0]  TICK_TABLE    = 32'h4844_2444
) (
  input  logic                     SC_MELODYSEQ_CLOCK_50,
  input  logic                     SC_MELODYSEQ_RESET_InLow,
  input  logic                     SC_MELODYSEQ_start_In,
  input  logic                     SC_MELODYSEQ_stop_In,
  input  logic                     SC_MELODYSEQ_loop_In,
  output logic [DIVIDER_WIDTH-1:0] SC_MELODYSEQ_divider_OutBUS,
  output logic                     SC_MELODYSEQ_toneEnable_Out,
  output logic [2:0]               SC_MELODYSEQ_step_OutBUS,
  output logic                     SC_MELODYSEQ_busy_Out,
  output logic                     SC_MELODYSEQ_done_Out
);

  localparam int            TICK_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [2:0]    STEP_LAST = 3'(NOTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               step_q, step_d;
  logic [TICK_W-1:0]        tick_q, tick_d;
  logic [3:0]               dur_q, dur_d;
  logic [DIVIDER_WIDTH-1:0] divider_q, divider_d;
  logic                     tone_q, tone_d;

  logic [3:0]               note_code;
  logic [3:0]               note_ticks;
  logic [DIVIDER_WIDTH-1:0] note_div;

  function automatic logic [DIVIDER_WIDTH-1:0] note_divider(input logic [3:0] code);
    case (code)
      4'd1:    return DIVIDER_WIDTH'(95420);
      4'd2:    return DIVIDER_WIDTH'(85034);
      4'd3:    return DIVIDER_WIDTH'(75758);
      4'd4:    return DIVIDER_WIDTH'(71633);
      4'd5:    return DIVIDER_WIDTH'(63776);
      4'd6:    return DIVIDER_WIDTH'(56818);
      4'd7:    return DIVIDER_WIDTH'(50607);
      4'd8:    return DIVIDER_WIDTH'(47801);
      default: return '0;
    endcase
  endfunction

  assign note_code  = CODE_TABLE[{step_q, 2'b00} +: 4];
  assign note_ticks = TICK_TABLE[{step_q, 2'b00} +: 4];
  assign note_div   = note_divider(note_code);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    tick_d    = tick_q;
    dur_d     = dur_q;
    divider_d = divider_q;
    tone_d    = tone_q;

    case (state_q)
      S_IDLE: begin
        step_d = '0;
        if (SC_MELODYSEQ_start_In && !SC_MELODYSEQ_stop_In) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (SC_MELODYSEQ_stop_In) begin
          state_d   = S_IDLE;
          step_d    = '0;
          tick_d    = '0;
          dur_d     = '0;
          divider_d = '0;
          tone_d    = 1'b0;
        end else begin
          // A zero tick count would underflow the duration counter, so play it as one tick.
          state_d   = S_PLAY;
          divider_d = note_div;
          tone_d    = (note_div != '0);
          dur_d     = (note_ticks == 4'd0) ? 4'd1 : note_ticks;
          tick_d    = '0;
        end
      end

      S_PLAY: begin
        if (SC_MELODYSEQ_stop_In) begin
          state_d   = S_IDLE;
          step_d    = '0;
          tick_d    = '0;
          dur_d     = '0;
          divider_d = '0;
          tone_d    = 1'b0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (dur_q <= 4'd1) begin
            dur_d = '0;
            if (step_q != STEP_LAST) begin
              step_d  = step_q + 3'd1;
              state_d = S_LOAD;
            end else if (SC_MELODYSEQ_loop_In) begin
              step_d  = '0;
              state_d = S_LOAD;
            end else begin
              state_d   = S_DONE;
              divider_d = '0;
              tone_d    = 1'b0;
            end
          end else begin
            dur_d = dur_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SC_MELODYSEQ_CLOCK_50 or negedge SC_MELODYSEQ_RESET_InLow) begin
    if (!SC_MELODYSEQ_RESET_InLow) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      tick_q    <= '0;
      dur_q     <= '0;
      divider_q <= '0;
      tone_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
      dur_q     <= dur_d;
      divider_q <= divider_d;
      tone_q    <= tone_d;
    end
  end

  assign SC_MELODYSEQ_divider_OutBUS = divider_q;
  assign SC_MELODYSEQ_toneEnable_Out = tone_q;
  assign SC_MELODYSEQ_step_OutBUS    = step_q;
  assign SC_MELODYSEQ_busy_Out       = (state_q == S_LOAD) || (state_q == S_PLAY);
  assign SC_MELODYSEQ_done_Out       = (state_q == S_DONE);

endmodule

// File: tb/tb_sc_melodyseq.sv
// Directed bench for sc_melodyseq: table-driven single run plus reset, loop, stop
// and zero-tick sequences. Main instance uses TICK_CYCLES=4, the second TICK_CYCLES=2.
module tb_sc_melodyseq;

  logic        clk;
  logic        rst_n;
  logic        start, stop, loop_i;
  logic [16:0] divider;
  logic        tone, busy, done;
  logic [2:0]  step;

  logic        start2, stop2, loop2;
  logic [16:0] divider2;
  logic        tone2, busy2, done2;
  logic [2:0]  step2;

  int checks = 0;
  int errors = 0;

  sc_melodyseq #(
    .DIVIDER_WIDTH(17),
    .TICK_CYCLES  (4)
  ) dut (
    .SC_MELODYSEQ_CLOCK_50      (clk),
    .SC_MELODYSEQ_RESET_InLow   (rst_n),
    .SC_MELODYSEQ_start_In      (start),
    .SC_MELODYSEQ_stop_In       (stop),
    .SC_MELODYSEQ_loop_In       (loop_i),
    .SC_MELODYSEQ_divider_OutBUS(divider),
    .SC_MELODYSEQ_toneEnable_Out(tone),
    .SC_MELODYSEQ_step_OutBUS   (step),
    .SC_MELODYSEQ_busy_Out      (busy),
    .SC_MELODYSEQ_done_Out      (done)
  );

  // Step 0 forced to zero ticks.
  sc_melodyseq #(
    .DIVIDER_WIDTH(17),
    .TICK_CYCLES  (2),
    .TICK_TABLE   (32'h4844_2440)
  ) dut2 (
    .SC_MELODYSEQ_CLOCK_50      (clk),
    .SC_MELODYSEQ_RESET_InLow   (rst_n),
    .SC_MELODYSEQ_start_In      (start2),
    .SC_MELODYSEQ_stop_In       (stop2),
    .SC_MELODYSEQ_loop_In       (loop2),
    .SC_MELODYSEQ_divider_OutBUS(divider2),
    .SC_MELODYSEQ_toneEnable_Out(tone2),
    .SC_MELODYSEQ_step_OutBUS   (step2),
    .SC_MELODYSEQ_busy_Out      (busy2),
    .SC_MELODYSEQ_done_Out      (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          edge_n;
    logic [16:0] div;
    logic        tone;
    logic        busy;
    logic        done;
    logic [2:0]  step;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic p, input logic l);
    start  = s;
    stop   = p;
    loop_i = l;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    start = 0; stop = 0; loop_i = 0;
    start2 = 0; stop2 = 0; loop2 = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check_output({tag, ".divider"}, 32'(divider), 32'(v.div));
    check_output({tag, ".tone"},    32'(tone),    32'(v.tone));
    check_output({tag, ".busy"},    32'(busy),    32'(v.busy));
    check_output({tag, ".done"},    32'(done),    32'(v.done));
    check_output({tag, ".step"},    32'(step),    32'(v.step));
  endtask

  initial begin
    int vi;
    int rest_cnt, high_cnt, done_n, done_e;
    vec_t idle_v;
    idle_v = '{0, 17'd0, 1'b0, 1'b0, 1'b0, 3'd0};

    // Expected outputs after a given edge of a single run started at edge 0.
    vecs.push_back('{1,   17'd95420, 1'b1, 1'b1, 1'b0, 3'd0});
    vecs.push_back('{17,  17'd95420, 1'b1, 1'b1, 1'b0, 3'd1});
    vecs.push_back('{18,  17'd85034, 1'b1, 1'b1, 1'b0, 3'd1});
    vecs.push_back('{35,  17'd75758, 1'b1, 1'b1, 1'b0, 3'd2});
    vecs.push_back('{51,  17'd75758, 1'b1, 1'b1, 1'b0, 3'd3});
    vecs.push_back('{52,  17'd0,     1'b0, 1'b1, 1'b0, 3'd3});
    vecs.push_back('{61,  17'd63776, 1'b1, 1'b1, 1'b0, 3'd4});
    vecs.push_back('{78,  17'd56818, 1'b1, 1'b1, 1'b0, 3'd5});
    vecs.push_back('{95,  17'd47801, 1'b1, 1'b1, 1'b0, 3'd6});
    vecs.push_back('{128, 17'd0,     1'b0, 1'b1, 1'b0, 3'd7});
    vecs.push_back('{143, 17'd0,     1'b0, 1'b1, 1'b0, 3'd7});
    vecs.push_back('{144, 17'd0,     1'b0, 1'b0, 1'b1, 3'd7});
    vecs.push_back('{145, 17'd0,     1'b0, 1'b0, 1'b0, 3'd0});
    vecs.push_back('{147, 17'd0,     1'b0, 1'b0, 1'b0, 3'd0});

    start = 0; stop = 0; loop_i = 0;
    start2 = 0; stop2 = 0; loop2 = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", idle_v);
    check_output("reset.busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    apply_stimulus(0, 0, 0);

    // Asynchronous reset in the middle of PLAY.
    apply_stimulus(1, 0, 0);
    for (int e = 1; e <= 10; e++) apply_stimulus(0, 0, 0);
    check_output("midplay.divider", 32'(divider), 32'd95420);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", idle_v);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) apply_stimulus(0, 0, 0);
    check_all("post_reset_idle", idle_v);

    // Single run, with an ignored start while busy at edge 20.
    reset_dut();
    apply_stimulus(1, 0, 0);
    vi = 0; rest_cnt = 0; high_cnt = 0; done_n = 0;
    for (int e = 1; e <= 147; e++) begin
      apply_stimulus(e == 20, 0, 0);
      if (busy && divider == 17'd0 && e < 100) rest_cnt++;
      if (divider == 17'd47801) high_cnt++;
      if (done) done_n++;
      if (vi < vecs.size() && vecs[vi].edge_n == e) begin
        check_all($sformatf("run@%0d", e), vecs[vi]);
        vi++;
      end
    end
    check_output("run.vectors_seen", 32'(vi), 32'(vecs.size()));
    check_output("run.rest_cycles", 32'(rest_cnt), 32'd9);
    check_output("run.step6_cycles", 32'(high_cnt), 32'd33);
    check_output("run.done_pulses", 32'(done_n), 32'd1);

    // Looping: wrap after step 7, then drop loop during the second pass.
    reset_dut();
    apply_stimulus(1, 0, 1);
    done_n = 0; done_e = -1;
    for (int e = 1; e <= 292; e++) begin
      apply_stimulus(0, 0, e <= 150);
      if (done) begin
        done_n++;
        done_e = e;
      end
      if (e == 144) begin
        check_output("loop.wrap_busy", 32'(busy), 32'd1);
        check_output("loop.wrap_step", 32'(step), 32'd0);
      end
      if (e == 145) begin
        check_output("loop.wrap_divider", 32'(divider), 32'd95420);
        check_output("loop.wrap_tone", 32'(tone), 32'd1);
      end
      if (e == 290) check_output("loop.end_busy", 32'(busy), 32'd0);
    end
    check_output("loop.done_pulses", 32'(done_n), 32'd1);
    check_output("loop.done_edge", 32'(done_e), 32'd288);

    // Stop during step 2, then start+stop together from IDLE.
    reset_dut();
    apply_stimulus(1, 0, 0);
    done_n = 0;
    for (int e = 1; e <= 45; e++) begin
      apply_stimulus(0, e == 40, 0);
      if (done) done_n++;
      if (e == 39) begin
        check_output("stop.pre_step", 32'(step), 32'd2);
        check_output("stop.pre_divider", 32'(divider), 32'd75758);
      end
      if (e == 40) check_all("stop.after", idle_v);
    end
    check_output("stop.done_pulses", 32'(done_n), 32'd0);
    apply_stimulus(1, 1, 0);
    check_all("startstop.same", idle_v);
    apply_stimulus(0, 0, 0);
    check_all("startstop.next", idle_v);

    // Zero-tick step on the TICK_CYCLES=2 instance lasts three cycles.
    reset_dut();
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        check_output("zt.divider", 32'(divider2), 32'd95420);
        check_output("zt.step_e1", 32'(step2), 32'd0);
      end
      if (e == 2)  check_output("zt.step_e2", 32'(step2), 32'd0);
      if (e == 3)  check_output("zt.step_e3", 32'(step2), 32'd1);
      if (e == 4)  check_output("zt.divider_s1", 32'(divider2), 32'd85034);
      if (e == 11) check_output("zt.step_e11", 32'(step2), 32'd1);
      if (e == 12) check_output("zt.step_e12", 32'(step2), 32'd2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
